receive_all: RTL and testbench

Receiving end of the inter-board link. It accepts the six-word, 4-phase Request/Ack transfer produced by the neighbouring board's sender, reassembles the words into one move message and hands it to GameControl as a one-cycle pulse. It also detects the held interboard-reset pattern (Request held high, data 6'b11_1111) and converts it into a one-cycle reset pulse for the local board.

---
 rtl/receive_all_pkg.sv | 31 +++
 rtl/receive_all_single.sv | 70 +++++++
 rtl/receive_all.sv | 127 ++++++++++++
 tb/tb_receive_all.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/receive_all_pkg.sv
// Inter-board link definitions shared by sender and receiver: word layout,
// message fields, reset pattern and handshake state encoding.
package receive_all_pkg;

  localparam int unsigned WORD_COUNT = 6;
  localparam int unsigned WORD_W     = 6;
  localparam int unsigned IDX_W      = 3;
  localparam int unsigned TYPE_W     = 4;
  localparam int unsigned BX_W       = 5;
  localparam int unsigned BY_W       = 3;
  localparam int unsigned CARD_W     = 6;
  localparam int unsigned SEL_W      = 3;

  localparam logic [WORD_W-1:0] RST_PATTERN = 6'h3F;
  localparam logic [IDX_W-1:0]  LAST_IDX    = 3'(WORD_COUNT - 1);

  typedef enum logic {
    WAIT_REQ_UP   = 1'b0,
    WAIT_REQ_DOWN = 1'b1
  } hs_state_e;

  typedef struct packed {
    logic [TYPE_W-1:0] msg_type;
    logic [BX_W-1:0]   block_x;
    logic [BY_W-1:0]   block_y;
    logic [CARD_W-1:0] card;
    logic [SEL_W-1:0]  sel_len;
    logic              move_dir;
  } move_msg_t;

endpackage

// File: rtl/receive_all_single.sv
// Single-word receiver: Request synchronizer, 4-phase handshake FSM and the
// captured word register with its one-cycle valid pulse.
module receive_all_single
  import receive_all_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic [WORD_W-1:0] data_i,
  output logic              ack_o,
  output logic              req_s_o,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  logic              req_m_q;
  logic              req_s_q;
  hs_state_e         state_q, state_d;
  logic [WORD_W-1:0] word_q, word_d;
  logic              word_valid_q, word_valid_d;

  // Synchronizer, handshake state and captured word
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      req_m_q      <= 1'b0;
      req_s_q      <= 1'b0;
      state_q      <= WAIT_REQ_UP;
      word_q       <= 6'd0;
      word_valid_q <= 1'b0;
    end else begin
      req_m_q      <= req_i;
      req_s_q      <= req_m_q;
      state_q      <= state_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
    end
  end

  // Data is sampled raw: it has been stable since Request rose two cycles ago
  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    case (state_q)
      WAIT_REQ_UP: begin
        if (req_s_q) begin
          state_d      = WAIT_REQ_DOWN;
          word_d       = data_i;
          word_valid_d = 1'b1;
        end else begin
          state_d = WAIT_REQ_UP;
        end
      end
      WAIT_REQ_DOWN: begin
        if (!req_s_q) begin
          state_d = WAIT_REQ_UP;
        end else begin
          state_d = WAIT_REQ_DOWN;
        end
      end
      default: state_d = WAIT_REQ_UP;
    endcase
  end

  assign ack_o        = (state_q == WAIT_REQ_DOWN);
  assign req_s_o      = req_s_q;
  assign word_o       = word_q;
  assign word_valid_o = word_valid_q;

endmodule

// File: rtl/receive_all.sv
// Receiving end of the inter-board link: assembles six handshake words into a
// move message and detects the held interboard-reset pattern.
module receive_all
  import receive_all_pkg::*;
#(
  parameter int unsigned RST_HOLD = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Request,
  input  logic [WORD_W-1:0] interboard_data,
  output logic              Ack,
  output logic              msg_valid,
  output logic [TYPE_W-1:0] msg_type,
  output logic [BX_W-1:0]   block_x,
  output logic [BY_W-1:0]   block_y,
  output logic [CARD_W-1:0] card,
  output logic [SEL_W-1:0]  sel_len,
  output logic              move_dir,
  output logic              interboard_rst_out
);

  localparam logic [7:0] HOLD_C = 8'(RST_HOLD);

  logic              req_s;
  logic [WORD_W-1:0] word;
  logic              word_valid;

  logic [IDX_W-1:0]  idx_q, idx_d;
  move_msg_t         shadow_q, shadow_d;
  move_msg_t         out_q, out_d;
  logic              msg_valid_q, msg_valid_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              blocked_q, blocked_d;
  logic              rst_pulse_q;
  logic              pattern;
  logic              fire;

  receive_all_single u_single (
    .clk_i        (clk),
    .rst_i        (rst),
    .req_i        (Request),
    .data_i       (interboard_data),
    .ack_o        (Ack),
    .req_s_o      (req_s),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  // Assembler, detector and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q       <= 3'd0;
      shadow_q    <= '{default: 1'b0};
      out_q       <= '{default: 1'b0};
      msg_valid_q <= 1'b0;
      cnt_q       <= 8'd0;
      blocked_q   <= 1'b0;
      rst_pulse_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      shadow_q    <= shadow_d;
      out_q       <= out_d;
      msg_valid_q <= msg_valid_d;
      cnt_q       <= cnt_d;
      blocked_q   <= blocked_d;
      rst_pulse_q <= fire;
    end
  end

  // Hold counter saturates at RST_HOLD; blocking stops a second pulse
  always_comb begin
    pattern = req_s && (interboard_data == RST_PATTERN);
    fire    = pattern && !blocked_q && (cnt_q == HOLD_C - 8'd1);
    if (!pattern) begin
      cnt_d = 8'd0;
    end else if (cnt_q != HOLD_C) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
    if (!req_s) begin
      blocked_d = 1'b0;
    end else if (fire) begin
      blocked_d = 1'b1;
    end else begin
      blocked_d = blocked_q;
    end
  end

  // Words fill the shadow; the last word publishes all fields at once
  always_comb begin
    idx_d       = idx_q;
    shadow_d    = shadow_q;
    out_d       = out_q;
    msg_valid_d = 1'b0;
    if (fire) begin
      idx_d = 3'd0;
    end else if (word_valid && !blocked_q) begin
      case (idx_q)
        3'd0: shadow_d.msg_type = word[TYPE_W-1:0];
        3'd1: shadow_d.block_x  = word[BX_W-1:0];
        3'd2: shadow_d.block_y  = word[BY_W-1:0];
        3'd3: shadow_d.card     = word[CARD_W-1:0];
        3'd4: shadow_d.sel_len  = word[SEL_W-1:0];
        default: begin
          out_d          = shadow_q;
          out_d.move_dir = word[0];
          msg_valid_d    = 1'b1;
        end
      endcase
      idx_d = (idx_q >= LAST_IDX) ? 3'd0 : idx_q + 3'd1;
    end else begin
      idx_d = idx_q;
    end
  end

  assign msg_valid          = msg_valid_q;
  assign msg_type           = out_q.msg_type;
  assign block_x            = out_q.block_x;
  assign block_y            = out_q.block_y;
  assign card               = out_q.card;
  assign sel_len            = out_q.sel_len;
  assign move_dir           = out_q.move_dir;
  assign interboard_rst_out = rst_pulse_q;

endmodule

// File: tb/tb_receive_all.sv
// Self-checking bench for receive_all: sender-like handshakes with random and
// directed words, checked against a field-extraction model.
module tb_receive_all;

  localparam int unsigned RST_HOLD = 64;

  logic       clk;
  logic       rst;
  logic       Request;
  logic [5:0] interboard_data;
  logic       Ack;
  logic       msg_valid;
  logic [3:0] msg_type;
  logic [4:0] block_x;
  logic [2:0] block_y;
  logic [5:0] card;
  logic [2:0] sel_len;
  logic       move_dir;
  logic       interboard_rst_out;

  int total = 0;
  int bad   = 0;

  int          n_msg  = 0;
  int          n_ack  = 0;
  int          n_both = 0;
  logic        ack_prev = 1'b0;
  logic [21:0] cap = 22'd0;
  logic [21:0] out_bus;
  logic [5:0]  words [6];

  assign out_bus = {msg_type, block_x, block_y, card, sel_len, move_dir};

  receive_all #(.RST_HOLD(RST_HOLD)) dut (
    .clk                (clk),
    .rst                (rst),
    .Request            (Request),
    .interboard_data    (interboard_data),
    .Ack                (Ack),
    .msg_valid          (msg_valid),
    .msg_type           (msg_type),
    .block_x            (block_x),
    .block_y            (block_y),
    .card               (card),
    .sel_len            (sel_len),
    .move_dir           (move_dir),
    .interboard_rst_out (interboard_rst_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    ack_prev <= Ack;
    if (Ack && !ack_prev) n_ack <= n_ack + 1;
    if (msg_valid) begin
      n_msg <= n_msg + 1;
      cap   <= out_bus;
    end
    if (msg_valid && interboard_rst_out) n_both <= n_both + 1;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "timeout");
  end

  // Each field is the low part of its word: plain modulo arithmetic
  function automatic logic [21:0] model_msg(input logic [5:0] w [6]);
    logic [3:0] t;
    logic [4:0] bx;
    logic [2:0] by;
    logic [5:0] c;
    logic [2:0] s;
    logic       d;
    t  = 4'(w[0] % 6'd16);
    bx = 5'(w[1] % 6'd32);
    by = 3'(w[2] % 6'd8);
    c  = w[3];
    s  = 3'(w[4] % 6'd8);
    d  = 1'(w[5] % 6'd2);
    return {t, bx, by, c, s, d};
  endfunction

  task automatic wait_ack(input logic lvl);
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (Ack === lvl) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL ack_wait: actual=%b required=%b", Ack, lvl);
    end
  endtask

  task automatic send_word(input logic [5:0] w);
    interboard_data = w;
    Request = 1'b1;
    wait_ack(1'b1);
    Request = 1'b0;
    wait_ack(1'b0);
    @(negedge clk);
  endtask

  task automatic send_msg(input logic [5:0] w [6]);
    for (int i = 0; i < 6; i++) send_word(w[i]);
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_words();
    for (int i = 0; i < 6; i++) words[i] = 6'($urandom_range(0, 62));
  endtask

  task automatic hold_pattern(input int cycles, output int pulses, output int hit, output int mv);
    pulses = 0; hit = 0; mv = 0;
    interboard_data = 6'h3F;
    Request = 1'b1;
    for (int e = 1; e <= cycles; e++) begin
      @(posedge clk); #1;
      if (interboard_rst_out) begin pulses++; hit = e; end
      if (msg_valid) mv++;
    end
    @(negedge clk);
    Request = 1'b0;
    wait_ack(1'b0);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    total++;
    if ({Ack, msg_valid, interboard_rst_out, out_bus} !== 25'd0) begin
      bad++;
      $display("FAIL reset_outputs: actual=%h required=0", {Ack, msg_valid, interboard_rst_out, out_bus});
    end
  endtask

  task automatic test_ack_timing();
    logic exp_up [3] = '{1'b0, 1'b0, 1'b1};
    logic exp_dn [3] = '{1'b1, 1'b1, 1'b0};
    @(negedge clk);
    interboard_data = 6'h15;
    Request = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      total++;
      if (Ack !== exp_up[e]) begin
        bad++;
        $display("FAIL ack_rise_edge%0d: actual=%b required=%b", e + 1, Ack, exp_up[e]);
      end
    end
    @(negedge clk);
    Request = 1'b0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      total++;
      if (Ack !== exp_dn[e]) begin
        bad++;
        $display("FAIL ack_fall_edge%0d: actual=%b required=%b", e + 1, Ack, exp_dn[e]);
      end
    end
    @(negedge clk);
    // finish this message so later tests start from word 0
    for (int i = 0; i < 5; i++) send_word(6'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic test_basic_message();
    int m0, a0;
    logic [21:0] spec_val;
    words = '{6'h05, 6'h13, 6'h06, 6'h2A, 6'h04, 6'h01};
    spec_val = {4'd5, 5'd19, 3'd6, 6'd42, 3'd4, 1'b1};
    m0 = n_msg; a0 = n_ack;
    send_msg(words);
    total++;
    if (cap !== spec_val) begin
      bad++;
      $display("FAIL basic_fields: actual=%h required=%h", cap, spec_val);
    end
    total++;
    if (n_msg - m0 != 1) begin
      bad++;
      $display("FAIL basic_msg_count: actual=%0d required=1", n_msg - m0);
    end
    total++;
    if (n_ack - a0 != 6) begin
      bad++;
      $display("FAIL basic_ack_count: actual=%0d required=6", n_ack - a0);
    end
  endtask

  task automatic test_upper_bits();
    logic [21:0] spec_val;
    words = '{6'h35, 6'h33, 6'h3E, 6'h2A, 6'h3C, 6'h3F};
    spec_val = {4'd5, 5'd19, 3'd6, 6'd42, 3'd4, 1'b1};
    send_msg(words);
    total++;
    if (cap !== spec_val) begin
      bad++;
      $display("FAIL upper_bits_fields: actual=%h required=%h", cap, spec_val);
    end
  endtask

  task automatic test_back_to_back();
    int m0;
    logic [21:0] exp_v;
    for (int k = 0; k < 5; k++) begin
      rand_words();
      exp_v = model_msg(words);
      m0 = n_msg;
      send_msg(words);
      total++;
      if (cap !== exp_v || n_msg - m0 != 1) begin
        bad++;
        $display("FAIL b2b_msg%0d: actual=%h count=%0d required=%h count=1", k, cap, n_msg - m0, exp_v);
      end
    end
  endtask

  task automatic test_reset_detect();
    int pulses, hit, mv;
    logic [21:0] exp_v;
    hold_pattern(200, pulses, hit, mv);
    total++;
    if (pulses != 1) begin
      bad++;
      $display("FAIL rstdet_pulses: actual=%0d required=1", pulses);
    end
    total++;
    if (hit != int'(RST_HOLD) + 2) begin
      bad++;
      $display("FAIL rstdet_cycle: actual=%0d required=%0d", hit, RST_HOLD + 2);
    end
    total++;
    if (mv != 0) begin
      bad++;
      $display("FAIL rstdet_no_msg: actual=%0d required=0", mv);
    end
    rand_words();
    exp_v = model_msg(words);
    send_msg(words);
    total++;
    if (cap !== exp_v) begin
      bad++;
      $display("FAIL rstdet_after_msg: actual=%h required=%h", cap, exp_v);
    end
  endtask

  task automatic test_partial_discard();
    int pulses, hit, mv, m0;
    logic [21:0] prev, exp_v;
    prev = out_bus;
    m0 = n_msg;
    for (int i = 0; i < 3; i++) send_word(6'($urandom_range(0, 62)));
    repeat (2) @(negedge clk);
    total++;
    if (out_bus !== prev) begin
      bad++;
      $display("FAIL partial_outputs_held: actual=%h required=%h", out_bus, prev);
    end
    hold_pattern(100, pulses, hit, mv);
    total++;
    if (pulses != 1 || mv != 0) begin
      bad++;
      $display("FAIL partial_hold: actual=pulses%0d/msgs%0d required=pulses1/msgs0", pulses, mv);
    end
    rand_words();
    exp_v = model_msg(words);
    send_msg(words);
    total++;
    if (cap !== exp_v || n_msg - m0 != 1) begin
      bad++;
      $display("FAIL partial_next_msg: actual=%h count=%0d required=%h count=1", cap, n_msg - m0, exp_v);
    end
  endtask

  task automatic test_rst_mid_message();
    int m0;
    logic [21:0] exp_v;
    m0 = n_msg;
    for (int i = 0; i < 4; i++) send_word(6'($urandom_range(0, 62)));
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({Ack, msg_valid, interboard_rst_out, out_bus} !== 25'd0) begin
      bad++;
      $display("FAIL rst_mid_outputs: actual=%h required=0", {Ack, msg_valid, interboard_rst_out, out_bus});
    end
    rst = 1'b0;
    @(negedge clk);
    rand_words();
    exp_v = model_msg(words);
    send_msg(words);
    total++;
    if (cap !== exp_v || n_msg - m0 != 1) begin
      bad++;
      $display("FAIL rst_mid_next_msg: actual=%h count=%0d required=%h count=1", cap, n_msg - m0, exp_v);
    end
  endtask

  initial begin
    rst = 1'b1;
    Request = 1'b0;
    interboard_data = 6'd0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_ack_timing();
    test_basic_message();
    test_upper_bits();
    test_back_to_back();
    test_reset_detect();
    test_partial_discard();
    test_rst_mid_message();
    total++;
    if (n_both != 0) begin
      bad++;
      $display("FAIL msg_and_rst_same_cycle: actual=%0d required=0", n_both);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
